// File: rtl/stack_pkg.sv
// Shared definitions for the stack instruction engine.
// Provides op encodings, error codes, FSM state type, default parameters and
// a helper that classifies ops as stack writes (PUSH/CALL) or reads (POP/RET).
package stack_pkg;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_OVF = 2'b01;
  localparam logic [1:0] ERR_UNF = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  // Empty-stack SP value; a read with SP here underflows.
  localparam logic [7:0] SP_RESET = 8'hFF;

  localparam logic [7:0]  STACK_LIMIT_DEF = 8'd192;
  localparam int unsigned ACK_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  function automatic logic op_is_write(logic [1:0] op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/stack_timeout_ctr.sv
// Saturating wait counter for bus masters.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous clear to zero (dominates inc)
//   inc      : count one waiting cycle
//   expire   : high in the cycle whose increment brings the count to Limit
module stack_timeout_ctr #(
  parameter  int unsigned Limit = 16,
  localparam int unsigned Width = $clog2(Limit + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != Width'(Limit))) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = inc & ~clear & (count_q == Width'(Limit - 1));

endmodule

// File: rtl/stack_engine.sv
// Sequencer for PUSH/POP/CALL/RET: reads SP, performs one data-memory access
// over a req/ack handshake, then strobes the SP update and reports a response.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   cmd_valid/ready/op/data   : command interface (accept on valid & ready)
//   sp_in                     : current R3 from the register file
//   sp_en, sp_op              : one-cycle SP update strobe (1 = inc, 0 = dec)
//   mem_req/we/addr/wdata     : memory request, held until ack or timeout
//   mem_ack, mem_rdata        : memory completion and same-cycle read data
//   rsp_valid/op/data/err     : one-cycle completion pulse and held results
module stack_engine
  import stack_pkg::*;
#(
  parameter logic [7:0]  STACK_LIMIT = STACK_LIMIT_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic [7:0] sp_in,
  output logic       sp_en,
  output logic       sp_op,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic       rsp_valid,
  output logic [1:0] rsp_op,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_err
);

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [1:0] rsp_op_q, rsp_op_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic [1:0] rsp_err_q, rsp_err_d;
  logic       ctr_clear, ctr_inc, ctr_expire;

  stack_timeout_ctr #(
    .Limit(ACK_TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (ctr_clear),
    .inc   (ctr_inc),
    .expire(ctr_expire)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_op_d   = rsp_op_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    ctr_clear  = 1'b1;
    ctr_inc    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d = cmd_op;
          if (op_is_write(cmd_op)) begin
            we_d    = 1'b1;
            addr_d  = sp_in;
            wdata_d = cmd_data;
          end else begin
            we_d   = 1'b0;
            addr_d = sp_in + 8'd1;
          end
          // Bounds errors skip the memory access entirely.
          if (op_is_write(cmd_op) && (sp_in == STACK_LIMIT)) begin
            rsp_op_d   = cmd_op;
            rsp_data_d = 8'h00;
            rsp_err_d  = ERR_OVF;
            state_d    = StDone;
          end else if (!op_is_write(cmd_op) && (sp_in == SP_RESET)) begin
            rsp_op_d   = cmd_op;
            rsp_data_d = 8'h00;
            rsp_err_d  = ERR_UNF;
            state_d    = StDone;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        ctr_clear = 1'b0;
        // Ack wins over a timeout expiring in the same cycle.
        if (mem_ack) begin
          rsp_op_d   = op_q;
          rsp_data_d = we_q ? 8'h00 : mem_rdata;
          rsp_err_d  = ERR_OK;
          state_d    = StDone;
        end else begin
          ctr_inc = 1'b1;
          if (ctr_expire) begin
            rsp_op_d   = op_q;
            rsp_data_d = 8'h00;
            rsp_err_d  = ERR_TMO;
            state_d    = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= OP_PUSH;
      we_q       <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      rsp_op_q   <= 2'b00;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= ERR_OK;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_op_q   <= rsp_op_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Decoded from state so an asynchronous reset drops mem_req at once.
  assign cmd_ready = (state_q == StIdle);
  assign mem_req   = (state_q == StAccess);
  assign rsp_valid = (state_q == StDone);
  assign sp_en     = rsp_valid && (rsp_err_q == ERR_OK);
  assign sp_op     = sp_en && !op_is_write(rsp_op_q);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_op    = rsp_op_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_stack_engine.sv
// Self-checking bench for stack_engine. The bench acts as the register file
// (R3 updated from sp_en/sp_op) and as the data memory, and predicts every
// response from an abstract stack model: an expected SP plus a memory array.
module tb_stack_engine;
  import stack_pkg::*;

  localparam logic [7:0] LIMIT = 8'd192;
  localparam int         TMO   = 16;

  logic       clk, rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data, sp_in;
  logic       sp_en, sp_op;
  logic       mem_req, mem_we, mem_ack;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       rsp_valid;
  logic [1:0] rsp_op, rsp_err;
  logic [7:0] rsp_data;

  stack_engine #(
    .STACK_LIMIT(LIMIT),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .sp_in    (sp_in),
    .sp_en    (sp_en),
    .sp_op    (sp_op),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid),
    .rsp_op   (rsp_op),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file stand-in for R3.
  logic [7:0] sp_reg;
  always @(posedge clk or posedge rst) begin
    if (rst) sp_reg <= 8'hFF;
    else if (sp_en) sp_reg <= sp_op ? sp_reg + 8'd1 : sp_reg - 8'd1;
  end
  assign sp_in = sp_reg;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_sp;
  logic [7:0] stk [256];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] top_addr();
    logic [7:0] a;
    a = exp_sp + 8'd1;
    return a;
  endfunction

  // Issue one command. ack_at = index of the request cycle carrying mem_ack
  // (0 = first cycle); negative means never acknowledge.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] data, input int ack_at,
                         input logic [7:0] rdata);
    logic       wr;
    logic [1:0] err;
    logic [7:0] addr;
    int         n;
    int         want_reqs;
    wr   = (op == OP_PUSH) || (op == OP_CALL);
    addr = wr ? exp_sp : top_addr();
    if (wr && exp_sp == LIMIT)         err = ERR_OVF;
    else if (!wr && exp_sp == 8'hFF)   err = ERR_UNF;
    else if (ack_at < 0 || ack_at >= TMO) err = ERR_TMO;
    else                               err = ERR_OK;
    want_reqs = (err == ERR_OK) ? ack_at + 1 : (err == ERR_TMO) ? TMO : 0;

    chk("cmd_ready_before", 16'(cmd_ready), 16'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (mem_req && n < 40) begin
      chk("mem_addr", 16'(mem_addr), 16'(addr));
      chk("mem_we", 16'(mem_we), 16'(wr));
      if (wr) chk("mem_wdata", 16'(mem_wdata), 16'(data));
      chk("sp_en_during_req", 16'(sp_en), 16'd0);
      chk("cmd_ready_during_req", 16'(cmd_ready), 16'd0);
      mem_ack   = (n == ack_at);
      mem_rdata = (n == ack_at) ? rdata : 8'($urandom);
      // Commands offered while busy must be ignored.
      cmd_valid = 1'($urandom);
      cmd_op    = 2'($urandom);
      n++;
      @(negedge clk);
    end
    mem_ack   = 1'b0;
    cmd_valid = 1'b0;
    chk("req_cycles", 16'(n), 16'(want_reqs));
    chk("rsp_valid", 16'(rsp_valid), 16'd1);
    chk("rsp_op", 16'(rsp_op), 16'(op));
    chk("rsp_err", 16'(rsp_err), 16'(err));
    chk("rsp_data", 16'(rsp_data), (err == ERR_OK && !wr) ? 16'(rdata) : 16'd0);
    chk("sp_en", 16'(sp_en), 16'(err == ERR_OK));
    chk("sp_op", 16'(sp_op), 16'(err == ERR_OK && !wr));
    chk("mem_req_in_done", 16'(mem_req), 16'd0);
    if (err == ERR_OK) begin
      if (wr) begin
        stk[exp_sp] = data;
        exp_sp = exp_sp - 8'd1;
      end else begin
        exp_sp = exp_sp + 8'd1;
      end
    end
    @(negedge clk);
    chk("sp_after", 16'(sp_in), 16'(exp_sp));
    chk("rsp_valid_after", 16'(rsp_valid), 16'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rop;
    int         rack;
    int         r;
    logic [1:0] held_err;
    logic [7:0] held_data;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 8'h00;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    exp_sp    = 8'hFF;
    foreach (stk[i]) stk[i] = 8'h00;

    // Reset state
    #12;
    chk("rst_cmd_ready", 16'(cmd_ready), 16'd1);
    chk("rst_mem_req", 16'(mem_req), 16'd0);
    chk("rst_mem_we", 16'(mem_we), 16'd0);
    chk("rst_mem_addr", 16'(mem_addr), 16'd0);
    chk("rst_mem_wdata", 16'(mem_wdata), 16'd0);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst_rsp_bus", {4'd0, rsp_op, rsp_err, rsp_data}, 16'd0);
    chk("rst_sp_en", 16'(sp_en), 16'd0);
    chk("rst_sp_op", 16'(sp_op), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // mem_ack while idle is ignored
    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ack_req", 16'(mem_req), 16'd0);
    chk("idle_ack_rsp", 16'(rsp_valid), 16'd0);
    chk("idle_ack_ready", 16'(cmd_ready), 16'd1);
    mem_ack = 1'b0;

    // Directed cases
    run_cmd(OP_PUSH, 8'hA5, 1, 8'h00);      // write FF, sp -> FE
    run_cmd(OP_POP, 8'h00, 3, 8'h3C);       // read FF, data 3C
    run_cmd(OP_POP, 8'h00, 0, 8'h00);       // underflow
    held_err  = rsp_err;
    held_data = rsp_data;
    chk("hold_rsp_err", 16'(held_err), 16'(ERR_UNF));
    chk("hold_rsp_data", 16'(held_data), 16'd0);
    run_cmd(OP_PUSH, 8'h11, 0, 8'h00);
    run_cmd(OP_RET, 8'h00, -1, 8'h00);      // timeout, SP unchanged
    run_cmd(OP_RET, 8'h00, TMO - 1, stk[top_addr()]); // ack on the last allowed cycle
    while (exp_sp != LIMIT) run_cmd(OP_PUSH, 8'($urandom), $urandom_range(0, 2), 8'h00);
    run_cmd(OP_CALL, 8'h42, 0, 8'h00);      // overflow
    run_cmd(OP_PUSH, 8'h43, 0, 8'h00);      // overflow

    // Randomized command stream
    repeat (60) begin
      rop = 2'($urandom);
      r   = $urandom_range(0, 9);
      if (r == 0)      rack = -1;
      else if (r == 1) rack = TMO - 1;
      else             rack = $urandom_range(0, 4);
      run_cmd(rop, 8'($urandom), rack, stk[top_addr()]);
    end

    // Reset in the middle of an access
    rop = (exp_sp == 8'hFF) ? OP_PUSH : OP_POP;
    cmd_valid = 1'b1;
    cmd_op    = rop;
    cmd_data  = 8'h77;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("pre_rst_mem_req", 16'(mem_req), 16'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_mem_req", 16'(mem_req), 16'd0);
    chk("async_rst_ready", 16'(cmd_ready), 16'd1);
    chk("async_rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("async_rst_sp_en", 16'(sp_en), 16'd0);
    @(negedge clk);
    chk("rst_hold_rsp_valid", 16'(rsp_valid), 16'd0);
    rst    = 1'b0;
    exp_sp = 8'hFF;
    run_cmd(OP_PUSH, 8'hC1, 0, 8'h00);      // write FF
    run_cmd(OP_PUSH, 8'hC2, 0, 8'h00);      // back-to-back, write FE

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_engine.md
Name: stack_engine

Overview:
- Sequencer for stack instructions PUSH, POP, CALL and RET.
- Reads the current SP (R3) from the register file, then performs one data-memory access through a req/ack handshake.
- Drives the register file's SP_EN/SP_OP so SP changes only after the access completes.
- Returns popped data or the return address to writeback/fetch, and flags overflow, underflow and memory timeout.

Parameters:
- STACK_LIMIT, 8'd192: lowest legal SP value. A PUSH or CALL with sp_in == STACK_LIMIT is an overflow.
- ACK_TIMEOUT, 16: maximum number of cycles mem_req is held waiting for mem_ack.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  engine idle; a command is accepted when cmd_valid & cmd_ready.
- cmd_op  input  2  00 PUSH, 01 POP, 10 CALL, 11 RET.
- cmd_data  input  8  PUSH operand or CALL return address (PC+1).
- sp_in  input  8  current R3 value from the register file.
- sp_en  output  1  one-cycle SP update strobe to the register file.
- sp_op  output  1  1 = increment, 0 = decrement; valid while sp_en is high.
- mem_req  output  1  memory access request, held until ack or timeout.
- mem_we  output  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  output  8  access address.
- mem_wdata  output  8  write data.
- mem_ack  input  1  access done; read data is valid in the same cycle.
- mem_rdata  input  8  read data.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_op  output  2  echo of the completed command's op.
- rsp_data  output  8  POP/RET data; 0 for PUSH/CALL.
- rsp_err  output  2  00 ok, 01 overflow, 10 underflow, 11 timeout.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - Outputs: cmd_ready=1. sp_en, sp_op, mem_req, mem_we, rsp_valid = 0. mem_addr, mem_wdata, rsp_data, rsp_op, rsp_err = 0. Timeout counter = 0.
  - Reset mid-access drops mem_req immediately and produces no sp_en.
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - cmd_ready=1. On accept, latch op and data and compute the address from sp_in.
  - PUSH/CALL: mem_addr = sp_in, mem_we=1, mem_wdata = cmd_data.
  - POP/RET: mem_addr = sp_in + 1 (8-bit), mem_we=0.
  - Overflow check: PUSH/CALL with sp_in == STACK_LIMIT. Underflow check: POP/RET with sp_in == 8'hFF.
  - On either error, go directly to DONE with the error code and no mem_req. Otherwise go to ACCESS.
- ACCESS:
  - mem_req=1, with address and data stable. cmd_ready=0.
  - The counter increments each cycle without mem_ack.
  - On mem_ack: capture mem_rdata for POP/RET, drop mem_req on the next edge, go to DONE with err=00.
  - If the count reaches ACK_TIMEOUT without ack: drop mem_req, go to DONE with err=11.
  - mem_ack seen in the cycle the count reaches ACK_TIMEOUT counts as success.
- DONE (exactly one cycle):
  - rsp_valid=1. rsp_op, rsp_data and rsp_err are valid.
  - If err=00: sp_en=1. sp_op=1 for POP/RET, 0 for PUSH/CALL.
  - If err≠00: sp_en=0 and SP is unchanged.
  - Next state is IDLE.
- Latency with zero-wait ack (ack in the first ACCESS cycle):
  - accept at cycle 0, mem_req at cycle 1, rsp_valid and sp_en at cycle 2, cmd_ready at cycle 3.
  - Back-to-back commands therefore see the updated sp_in.
- cmd_valid outside IDLE is ignored and does not stall anything.
- mem_ack outside ACCESS is ignored.
- rsp_data and rsp_err hold their values until the next DONE. rsp_valid is the qualifier.
- sp_en never coincides with mem_req.

Decomposition:
- Shared package stack_pkg:
  - op encodings: OP_PUSH, OP_POP, OP_CALL, OP_RET.
  - error codes: ERR_OK, ERR_OVF, ERR_UNF, ERR_TMO.
  - FSM state encoding.
  - SP_RESET = 8'hFF.
- One sub-module, stack_timeout_ctr: a saturating counter with clear and expire outputs, reused by other bus masters.

Test Plan:
- PUSH 8'hA5 with sp_in=8'hFF and mem_ack one cycle after req:
  - required: write to 8'hFF with data 8'hA5, then rsp_err=00 and sp_en=1 with sp_op=0 in the same cycle.
- POP with sp_in=8'hFE and mem_rdata=8'h3C, ack after 3 cycles:
  - required: read address 8'hFF, then rsp_data=8'h3C and sp_en=1 with sp_op=1.
- POP with sp_in=8'hFF:
  - required: no mem_req, rsp_err=10, sp_en=0.
- CALL with sp_in=STACK_LIMIT (8'hC0):
  - required: no mem_req, rsp_err=01.
- RET with mem_ack never asserted:
  - required: mem_req high for exactly 16 cycles, then rsp_err=11, sp_en=0.
- rst asserted during ACCESS, then two back-to-back PUSHes (sp_in modelled from sp_en):
  - required on reset: mem_req falls asynchronously, no rsp_valid, cmd_ready=1.
  - required for the PUSHes: writes to 8'hFF then 8'hFE.
